// File: rtl/const_table_arbiter_pkg.sv
// Shared constant table, widths and arbiter state type for const_table_arbiter.
// CONST_TABLE_ARB_RANGE_CHECK_EN widens IDX_W by one bit so out-of-range indices become expressible.
package const_table_pkg;

  localparam int DATA_W      = 32;
  localparam int TABLE_DEPTH = 8;
`ifdef CONST_TABLE_ARB_RANGE_CHECK_EN
  localparam int IDX_W       = $clog2(TABLE_DEPTH) + 1;
`else
  localparam int IDX_W       = $clog2(TABLE_DEPTH);
`endif

  localparam logic [DATA_W-1:0] CONST_TABLE [TABLE_DEPTH] = '{
    32'd555, 32'd556, 32'd557, 32'd558, 32'd559, 32'd666, 32'd667, 32'd777
  };

  typedef enum logic {ARB, HOLD} arb_state_e;

  // Equality-match lookup: any index without a table entry reads as zero.
  function automatic logic [DATA_W-1:0] table_lookup(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (idx == IDX_W'(i)) v = CONST_TABLE[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/const_table_arbiter_if.sv
// Request/response bundle between table clients (master) and const_table_arbiter (slave).
// rsp_err only carries information when CONST_TABLE_ARB_RANGE_CHECK_EN is defined.
interface const_table_arbiter_if
  import const_table_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_lock;
  logic [N_REQ-1:0][IDX_W-1:0] req_idx;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_W-1:0]           rsp_data;
  logic                        rsp_err;

  modport master (
    output req_valid, req_lock, req_idx,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_lock, req_idx,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/const_table_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
// No configuration macros.
module const_table_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  always_comb begin : pick
    logic [W:0]   w_sum;
    logic [W-1:0] w_k;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, i_ptr} + (W+1)'(i);
      if (w_sum >= (W+1)'(N)) w_sum = w_sum - (W+1)'(N);
      w_k = w_sum[W-1:0];
      if (!o_any && i_req[w_k]) begin
        o_any        = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = w_k;
      end
    end
  end

endmodule

// File: rtl/const_table_arbiter.sv
// Round-robin arbiter sharing one constant table among N_REQ lookup clients, with lock/hold.
// CONST_TABLE_ARB_RANGE_CHECK_EN enables rsp_err and a one-hot check on req_ready.
module const_table_arbiter
  import const_table_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 4
) (
  input logic                   clk,
  input logic                   rst,
  const_table_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_e        r_state, w_state_nxt;
  logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [PTR_W-1:0]  r_owner, w_owner_nxt;
  logic [7:0]        r_hold_cnt, w_hold_cnt_nxt;

  logic [N_REQ-1:0]  w_pick_grant;
  logic [PTR_W-1:0]  w_pick_idx;
  logic              w_pick_any;

  logic [N_REQ-1:0]  w_ready;
  logic              w_accept;
  logic [PTR_W-1:0]  w_acc_id;
  logic [IDX_W-1:0]  w_acc_idx;

  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  function automatic logic [PTR_W-1:0] ptr_succ(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  const_table_arbiter_rr_pick #(.N(N_REQ), .W(PTR_W)) u_rr_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_hold_cnt_nxt = r_hold_cnt;
    w_ready        = '0;
    w_accept       = 1'b0;
    w_acc_id       = r_owner;
    if (!rst) begin
      case (r_state)
        ARB: begin
          w_ready  = w_pick_grant;
          w_accept = w_pick_any;
          w_acc_id = w_pick_idx;
          if (w_pick_any) begin
            w_rr_ptr_nxt = ptr_succ(w_pick_idx);
            // With MAX_HOLD of 1 the first accept already exhausts the hold budget.
            if (bus.req_lock[w_pick_idx] && (MAX_HOLD > 1)) begin
              w_state_nxt    = HOLD;
              w_owner_nxt    = w_pick_idx;
              w_hold_cnt_nxt = 8'd1;
            end
          end
        end
        HOLD: begin
          w_ready[r_owner] = bus.req_valid[r_owner];
          w_accept         = bus.req_valid[r_owner];
          if (w_accept) begin
            w_hold_cnt_nxt = r_hold_cnt + 8'd1;
            if (!bus.req_lock[r_owner] || ((r_hold_cnt + 8'd1) >= 8'(MAX_HOLD))) begin
              w_state_nxt    = ARB;
              w_hold_cnt_nxt = '0;
              w_rr_ptr_nxt   = ptr_succ(r_owner);
            end
          end else begin
            w_state_nxt    = ARB;
            w_hold_cnt_nxt = '0;
          end
        end
        default: w_state_nxt = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign w_acc_idx = bus.req_idx[w_acc_id];

  // w_ready is already qualified by req_valid, so it doubles as the accept one-hot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_ready;
      if (w_accept) r_rsp_data <= table_lookup(w_acc_idx);
    end
  end

`ifdef CONST_TABLE_ARB_RANGE_CHECK_EN
  logic r_rsp_err;

  always_ff @(posedge clk) begin
    if (rst) r_rsp_err <= 1'b0;
    else     r_rsp_err <= w_accept && (w_acc_idx >= IDX_W'(TABLE_DEPTH));
  end

  assign bus.rsp_err = r_rsp_err;

  always_ff @(posedge clk) begin
    if (!rst) assert ($countones(w_ready) <= 1);
  end
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;

endmodule
